// File: rtl/mbox_mux_pkg.sv
// Shared types for the two-master AXI-Lite mailbox arbiter.
package mbox_mux_pkg;

  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned StrbWidth  = DataWidth / 8;
  // Grant index is sized for the largest supported configuration (4 masters).
  localparam int unsigned MaxMasters = 4;

  typedef logic [$clog2(MaxMasters)-1:0] grant_idx_t;

  typedef enum logic [1:0] {WIdle, WFwd, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFwd, RResp} r_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] aw_addr;
    logic [2:0]           aw_prot;
    logic                 aw_valid;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_valid;
    logic                 b_ready;
    logic [AddrWidth-1:0] ar_addr;
    logic [2:0]           ar_prot;
    logic                 ar_valid;
    logic                 r_ready;
  } axi_lite_req_s;

  typedef struct packed {
    logic                 aw_ready;
    logic                 w_ready;
    logic [1:0]           b_resp;
    logic                 b_valid;
    logic                 ar_ready;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_valid;
  } axi_lite_rsp_s;

endpackage

// File: rtl/mbox_rr_arb.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module mbox_rr_arb
  import mbox_mux_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  grant_idx_t             ptr_i,
  output grant_idx_t             gnt_idx_o,
  output logic                   gnt_valid_o
);

  int unsigned cand;

  // Walk candidates ptr, ptr+1, ... with wrap; lock onto the first one requesting.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = (32'(ptr_i) + k) % NUM_MASTERS;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!gnt_valid_o && (i == cand) && req_i[i]) begin
          gnt_idx_o   = grant_idx_t'(i);
          gnt_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_mbox_mux.sv
// Arbitrates up to four AXI-Lite masters onto one mailbox slave; independent write and
// read paths, one outstanding transaction per path, round-robin ownership.
module axi_lite_mbox_mux
  import mbox_mux_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter type         axi_lite_req_t  = axi_lite_req_s,
  parameter type         axi_lite_resp_t = axi_lite_rsp_s
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_lite_req_t  slv_req_i [NUM_MASTERS],
  output axi_lite_resp_t slv_rsp_o [NUM_MASTERS],
  output axi_lite_req_t  mst_req_o,
  input  axi_lite_resp_t mst_rsp_i
);

  w_state_e   w_state_q, w_state_d;
  r_state_e   r_state_q, r_state_d;
  grant_idx_t w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  grant_idx_t w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NUM_MASTERS-1:0] aw_req, ar_req;
  grant_idx_t             w_gnt_idx, r_gnt_idx;
  logic                   w_gnt_valid, r_gnt_valid;
  axi_lite_req_t          w_sel, r_sel;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_fwd, ar_addr_fwd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  function automatic grant_idx_t next_idx(grant_idx_t idx);
    if (32'(idx) >= NUM_MASTERS - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Gather request vectors and select the current owners' request bundles.
  always_comb begin
    aw_req = '0;
    ar_req = '0;
    w_sel  = '0;
    r_sel  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      aw_req[i] = slv_req_i[i].aw_valid;
      ar_req[i] = slv_req_i[i].ar_valid;
      if (grant_idx_t'(i) == w_idx_q) w_sel = slv_req_i[i];
      if (grant_idx_t'(i) == r_idx_q) r_sel = slv_req_i[i];
    end
  end

  assign aw_addr_fwd = w_sel.aw_addr;
  assign ar_addr_fwd = r_sel.ar_addr;

  mbox_rr_arb #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_w_arb (
    .req_i      (aw_req),
    .ptr_i      (w_ptr_q),
    .gnt_idx_o  (w_gnt_idx),
    .gnt_valid_o(w_gnt_valid)
  );

  mbox_rr_arb #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_r_arb (
    .req_i      (ar_req),
    .ptr_i      (r_ptr_q),
    .gnt_idx_o  (r_gnt_idx),
    .gnt_valid_o(r_gnt_valid)
  );

  // Channel muxing: only the owner of a path sees its readys/valids; everything else is 0.
  always_comb begin
    mst_req_o = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) slv_rsp_o[i] = '0;
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_hs  = 1'b0;
    ar_hs = 1'b0;
    r_hs  = 1'b0;

    if (w_state_q == WFwd) begin
      // Done flags stop a channel from being forwarded twice while the other catches up.
      mst_req_o.aw_valid = w_sel.aw_valid & ~aw_done_q;
      mst_req_o.aw_addr  = aw_addr_fwd;
      mst_req_o.aw_prot  = w_sel.aw_prot;
      mst_req_o.w_valid  = w_sel.w_valid & ~w_done_q;
      mst_req_o.w_data   = w_sel.w_data;
      mst_req_o.w_strb   = w_sel.w_strb;
      aw_hs = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
      w_hs  = mst_req_o.w_valid & mst_rsp_i.w_ready;
    end else if (w_state_q == WResp) begin
      mst_req_o.b_ready = w_sel.b_ready;
      b_hs = mst_rsp_i.b_valid & w_sel.b_ready;
    end

    if (r_state_q == RFwd) begin
      mst_req_o.ar_valid = r_sel.ar_valid;
      mst_req_o.ar_addr  = ar_addr_fwd;
      mst_req_o.ar_prot  = r_sel.ar_prot;
      ar_hs = r_sel.ar_valid & mst_rsp_i.ar_ready;
    end else if (r_state_q == RResp) begin
      mst_req_o.r_ready = r_sel.r_ready;
      r_hs = mst_rsp_i.r_valid & r_sel.r_ready;
    end

    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_t'(i) == w_idx_q) begin
        if (w_state_q == WFwd) begin
          slv_rsp_o[i].aw_ready = mst_rsp_i.aw_ready & ~aw_done_q;
          slv_rsp_o[i].w_ready  = mst_rsp_i.w_ready & ~w_done_q;
        end else if (w_state_q == WResp) begin
          slv_rsp_o[i].b_valid = mst_rsp_i.b_valid;
          slv_rsp_o[i].b_resp  = mst_rsp_i.b_resp;
        end
      end
      if (grant_idx_t'(i) == r_idx_q) begin
        if (r_state_q == RFwd) begin
          slv_rsp_o[i].ar_ready = mst_rsp_i.ar_ready;
        end else if (r_state_q == RResp) begin
          slv_rsp_o[i].r_valid = mst_rsp_i.r_valid;
          slv_rsp_o[i].r_data  = mst_rsp_i.r_data;
          slv_rsp_o[i].r_resp  = mst_rsp_i.r_resp;
        end
      end
    end
  end

  // Write FSM next state: grant, forward AW/W in any order, then wait for B.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_ptr_d   = w_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (w_state_q)
      WIdle: begin
        if (w_gnt_valid) begin
          w_idx_d   = w_gnt_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WFwd;
        end
      end
      WFwd: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WResp;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WResp: begin
        if (b_hs) begin
          w_ptr_d   = next_idx(w_idx_q);
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM next state: grant, forward AR, then wait for R.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_ptr_d   = r_ptr_q;
    unique case (r_state_q)
      RIdle: begin
        if (r_gnt_valid) begin
          r_idx_d   = r_gnt_idx;
          r_state_d = RFwd;
        end
      end
      RFwd: begin
        if (ar_hs) r_state_d = RResp;
      end
      RResp: begin
        if (r_hs) begin
          r_ptr_d   = next_idx(r_idx_q);
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      w_idx_q   <= '0;
      r_idx_q   <= '0;
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_idx_q   <= w_idx_d;
      r_idx_q   <= r_idx_d;
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_mbox_mux.sv
// Directed bench for axi_lite_mbox_mux with a mailbox slave model and response scoreboards.
module tb_axi_lite_mbox_mux;
  import mbox_mux_pkg::*;

  localparam int unsigned N = 2;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  axi_lite_req_s slv_req [N];
  axi_lite_rsp_s slv_rsp [N];
  axi_lite_req_s mst_req;
  axi_lite_rsp_s mst_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_mbox_mux #(
    .NUM_MASTERS   (N),
    .AXI_ADDR_WIDTH(64)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .slv_req_i(slv_req),
    .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req),
    .mst_rsp_i(mst_rsp)
  );

  typedef struct {
    int          m;
    logic [63:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } wr_rec_t;
  typedef struct {
    int          m;
    logic [31:0] data;
  } rd_rec_t;

  wr_rec_t wq[$];
  rd_rec_t rq[$];
  wr_rec_t wrec;
  rd_rec_t rrec;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mailbox slave model: always ready, B one cycle after both AW and W, R one cycle after AR.
  logic        aw_got, w_got, b_hold;
  logic [63:0] cap_addr;
  logic [31:0] cap_data;

  function automatic logic [31:0] rd_fn(input logic [63:0] a);
    if (a == 64'h20) return 32'h0000_00AB;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_rsp  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      mst_rsp.aw_ready <= 1'b1;
      mst_rsp.w_ready  <= 1'b1;
      mst_rsp.ar_ready <= 1'b1;
      if (mst_req.aw_valid && mst_rsp.aw_ready) begin
        aw_got   <= 1'b1;
        cap_addr <= mst_req.aw_addr;
      end
      if (mst_req.w_valid && mst_rsp.w_ready) begin
        w_got    <= 1'b1;
        cap_data <= mst_req.w_data;
      end
      if (aw_got && w_got && !mst_rsp.b_valid && !b_hold) begin
        mst_rsp.b_valid <= 1'b1;
        mst_rsp.b_resp  <= (cap_addr == 64'h30) ? 2'b10 : 2'b00;
        aw_got          <= 1'b0;
        w_got           <= 1'b0;
      end
      if (mst_rsp.b_valid && mst_req.b_ready) mst_rsp.b_valid <= 1'b0;
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        mst_rsp.r_valid <= 1'b1;
        mst_rsp.r_data  <= rd_fn(mst_req.ar_addr);
        mst_rsp.r_resp  <= 2'b00;
      end
      if (mst_rsp.r_valid && mst_req.r_ready) mst_rsp.r_valid <= 1'b0;
    end
  end

  // Response monitor: pop scoreboard on every B/R delivered, and check single ownership.
  int nw, nr;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      nw = 0;
      nr = 0;
      for (int m = 0; m < N; m++) begin
        if (slv_rsp[m].aw_ready || slv_rsp[m].w_ready || slv_rsp[m].b_valid) nw++;
        if (slv_rsp[m].ar_ready || slv_rsp[m].r_valid) nr++;
        if (slv_rsp[m].b_valid && slv_req[m].b_ready) begin
          if (wq.size() == 0) begin
            check("b_unexpected", 192'(m), 192'hFF);
          end else begin
            wrec = wq.pop_front();
            check("b_master", 192'(m), 192'(wrec.m));
            check("b_resp", slv_rsp[m].b_resp, wrec.resp);
            check("w_addr", cap_addr, wrec.addr);
            check("w_data", cap_data, wrec.data);
          end
        end
        if (slv_rsp[m].r_valid && slv_req[m].r_ready) begin
          if (rq.size() == 0) begin
            check("r_unexpected", 192'(m), 192'hFF);
          end else begin
            rrec = rq.pop_front();
            check("r_master", 192'(m), 192'(rrec.m));
            check("r_data", slv_rsp[m].r_data, rrec.data);
          end
        end
      end
      check("wr_one_owner", 192'(nw <= 1), 192'd1);
      check("rd_one_owner", 192'(nr <= 1), 192'd1);
    end
  end

  // Master-side write: W may lead AW by w_lead cycles; returns after the B handshake.
  task automatic do_write(input int m, input logic [63:0] a, input logic [31:0] d,
                          input int w_lead);
    bit aw_hs, w_hs, b_hs, done;
    int cyc;
    done = 0;
    cyc  = 0;
    slv_req[m].aw_addr  = a;
    slv_req[m].aw_prot  = 3'b010;
    slv_req[m].w_data   = d;
    slv_req[m].w_strb   = 4'hF;
    slv_req[m].b_ready  = 1'b1;
    slv_req[m].w_valid  = 1'b1;
    slv_req[m].aw_valid = (w_lead == 0);
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      aw_hs = slv_req[m].aw_valid && slv_rsp[m].aw_ready;
      w_hs  = slv_req[m].w_valid && slv_rsp[m].w_ready;
      b_hs  = slv_rsp[m].b_valid && slv_req[m].b_ready;
      @(posedge clk_i);
      #1;
      cyc++;
      if (aw_hs) slv_req[m].aw_valid = 1'b0;
      if (w_hs) slv_req[m].w_valid = 1'b0;
      if (b_hs) begin
        slv_req[m].b_ready = 1'b0;
        done = 1;
      end
      if (cyc == w_lead) slv_req[m].aw_valid = 1'b1;
    end
    check("wr_done", 192'(done), 192'd1);
  endtask

  task automatic do_read(input int m, input logic [63:0] a);
    bit ar_hs, r_hs, done;
    int cyc;
    done = 0;
    cyc  = 0;
    slv_req[m].ar_addr  = a;
    slv_req[m].ar_prot  = 3'b000;
    slv_req[m].ar_valid = 1'b1;
    slv_req[m].r_ready  = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      ar_hs = slv_req[m].ar_valid && slv_rsp[m].ar_ready;
      r_hs  = slv_rsp[m].r_valid && slv_req[m].r_ready;
      @(posedge clk_i);
      #1;
      cyc++;
      if (ar_hs) slv_req[m].ar_valid = 1'b0;
      if (r_hs) begin
        slv_req[m].r_ready = 1'b0;
        done = 1;
      end
    end
    check("rd_done", 192'(done), 192'd1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((wq.size() != 0 || rq.size() != 0) && cyc < 500) begin
      @(posedge clk_i);
      cyc++;
    end
    check("drain", 192'(wq.size() + rq.size()), 192'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int cyc;
    for (int m = 0; m < N; m++) slv_req[m] = '0;
    b_hold = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_mst_req", mst_req, '0);
    check("rst_slv_rsp0", slv_rsp[0], '0);
    check("rst_slv_rsp1", slv_rsp[1], '0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single write from master 1, with one-cycle arbitration latency.
    wq.push_back('{m: 1, addr: 64'h10, data: 32'hDEAD_BEEF, resp: 2'b00});
    fork
      do_write(1, 64'h10, 32'hDEAD_BEEF, 0);
      begin
        @(negedge clk_i);
        check("lat_idle_aw", mst_req.aw_valid, 1'b0);
        @(negedge clk_i);
        check("lat_aw", mst_req.aw_valid, 1'b1);
        check("lat_addr", mst_req.aw_addr, 64'h10);
        check("lat_w", mst_req.w_valid, 1'b1);
        check("lat_wdata", mst_req.w_data, 32'hDEAD_BEEF);
        check("lat_m0_noready", slv_rsp[0].aw_ready, 1'b0);
        check("lat_m1_ready", slv_rsp[1].aw_ready, 1'b1);
      end
    join
    drain();

    // Contention: both request together, pointer at 0.
    wq.push_back('{m: 0, addr: 64'h40, data: 32'h1111_1111, resp: 2'b00});
    wq.push_back('{m: 1, addr: 64'h44, data: 32'h2222_2222, resp: 2'b00});
    fork
      do_write(0, 64'h40, 32'h1111_1111, 0);
      do_write(1, 64'h44, 32'h2222_2222, 0);
    join
    drain();

    // Fairness: four back-to-back writes from each master alternate grants.
    for (int k = 0; k < 4; k++) begin
      wq.push_back('{m: 0, addr: 64'(32'h100 + 8 * k), data: 32'hA0 + k, resp: 2'b00});
      wq.push_back('{m: 1, addr: 64'(32'h104 + 8 * k), data: 32'hB0 + k, resp: 2'b00});
    end
    fork
      begin
        for (int k = 0; k < 4; k++) do_write(0, 64'(32'h100 + 8 * k), 32'hA0 + k, 0);
      end
      begin
        for (int k = 0; k < 4; k++) do_write(1, 64'(32'h104 + 8 * k), 32'hB0 + k, 0);
      end
    join
    drain();

    // W leads AW by two cycles; slave answers SLVERR for 0x30 to show resp passthrough.
    wq.push_back('{m: 0, addr: 64'h30, data: 32'h3333_3333, resp: 2'b10});
    fork
      do_write(0, 64'h30, 32'h3333_3333, 2);
      begin
        @(negedge clk_i);
        check("wlead_w0", mst_req.w_valid, 1'b0);
        @(negedge clk_i);
        check("wlead_w1", mst_req.w_valid, 1'b0);
      end
    join
    drain();

    // Parallel read (master 0) and write (master 1).
    rq.push_back('{m: 0, data: 32'h0000_00AB});
    wq.push_back('{m: 1, addr: 64'h24, data: 32'h2424_2424, resp: 2'b00});
    fork
      do_read(0, 64'h20);
      do_write(1, 64'h24, 32'h2424_2424, 0);
    join
    drain();

    // Read contention: read pointer now at 1, so master 1 goes first.
    rq.push_back('{m: 1, data: 32'h5A5A_0054});
    rq.push_back('{m: 0, data: 32'h5A5A_0050});
    fork
      do_read(0, 64'h50);
      do_read(1, 64'h54);
    join
    drain();

    // Leave the write pointer at 1 before the reset test.
    wq.push_back('{m: 0, addr: 64'h60, data: 32'h6060_6060, resp: 2'b00});
    do_write(0, 64'h60, 32'h6060_6060, 0);
    drain();

    // Reset while waiting for B: transaction dropped, pointer back to 0.
    b_hold = 1'b1;
    slv_req[1].aw_addr  = 64'h70;
    slv_req[1].w_data   = 32'h7070_7070;
    slv_req[1].w_strb   = 4'hF;
    slv_req[1].aw_valid = 1'b1;
    slv_req[1].w_valid  = 1'b1;
    cyc = 0;
    while (!(aw_got && w_got) && cyc < 50) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    check("rst_test_accepted", 192'(aw_got && w_got), 192'd1);
    slv_req[1] = '0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async_mst", mst_req, '0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    b_hold = 1'b0;
    @(negedge clk_i);
    check("post_rst_mst", mst_req, '0);
    check("post_rst_rsp0", slv_rsp[0], '0);
    check("post_rst_rsp1", slv_rsp[1], '0);
    @(posedge clk_i);
    #1;
    wq.push_back('{m: 0, addr: 64'h80, data: 32'h8080_8080, resp: 2'b00});
    wq.push_back('{m: 1, addr: 64'h84, data: 32'h8484_8484, resp: 2'b00});
    fork
      do_write(0, 64'h80, 32'h8080_8080, 0);
      do_write(1, 64'h84, 32'h8484_8484, 0);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
